// File: rtl/iq_ram_polling_pkg.sv
// iq_ram_polling_pkg: register map offsets, CTRL/STATUS bit positions and capture FSM states
package iq_ram_polling_pkg;
   localparam int REG_CTRL   = 'h00;
   localparam int REG_STATUS = 'h04;
   localparam int REG_DECIM  = 'h08;
   localparam int REG_FILL   = 'h0C;
   localparam int CTRL_START   = 0;
   localparam int CTRL_CLR_OVF = 1;
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVF  = 2;
   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;
endpackage

// File: rtl/iq_ram_polling_mc_ram.sv
// iq_ram_polling_mc_ram: per-channel banked dual-port RAM, all banks written together,
// one bank read per cycle through a registered read port
module iq_ram_polling_mc_ram #(
   parameter int DATA_W     = 32,
   parameter int NB_CHAN    = 2,
   parameter int CHAN_LOG2  = 1,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                            clk,
   input  logic                            we,
   input  logic [DEPTH_LOG2-1:0]           waddr,
   input  logic [NB_CHAN*DATA_W-1:0]       wdata,
   input  logic [CHAN_LOG2+DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]               rdata
);
   logic [DATA_W-1:0]    bank_rd [NB_CHAN];
   logic [CHAN_LOG2-1:0] rsel_q;
   for (genvar c = 0; c < NB_CHAN; c++) begin : g_bank
      logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata[c*DATA_W +: DATA_W];
         rd_q <= mem[raddr[DEPTH_LOG2-1:0]];
      end
      assign bank_rd[c] = rd_q;
   end
   always_ff @(posedge clk) rsel_q <= raddr[DEPTH_LOG2 +: CHAN_LOG2];
   always_comb rdata = (int'(rsel_q) < NB_CHAN) ? bank_rd[rsel_q] : '0;
endmodule

// File: rtl/iq_ram_polling_mc.sv
// iq_ram_polling_mc: multi-channel I/Q capture into RAM with decimation and sticky overflow,
// polled by the PS over AXI4-Lite
module iq_ram_polling_mc
   import iq_ram_polling_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 12,
   parameter int DATA_SIZE            = 16,
   parameter int NB_CHAN              = 2,
   parameter int CHAN_LOG2            = 1,
   parameter int RAM_DEPTH_LOG2       = 8
) (
   input  logic                                s00_axi_aclk,
   input  logic                                s00_axi_reset,
   input  logic                                data_en_i,
   input  logic [NB_CHAN*DATA_SIZE-1:0]        data_i_i,
   input  logic [NB_CHAN*DATA_SIZE-1:0]        data_q_i,
   output logic                                irq_o,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic                                s00_axi_awvalid,
   output logic                                s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                                s00_axi_wvalid,
   output logic                                s00_axi_wready,
   output logic [1:0]                          s00_axi_bresp,
   output logic                                s00_axi_bvalid,
   input  logic                                s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic                                s00_axi_arvalid,
   output logic                                s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                          s00_axi_rresp,
   output logic                                s00_axi_rvalid,
   input  logic                                s00_axi_rready
);
   localparam int AW = C_S00_AXI_ADDR_WIDTH;
   localparam int DW = C_S00_AXI_DATA_WIDTH;
   localparam int SW = 2*DATA_SIZE;
   localparam int PW = RAM_DEPTH_LOG2 + 1;
   localparam int RW = CHAN_LOG2 + RAM_DEPTH_LOG2;
   state_e            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [15:0]       dcnt_q, dcnt_d, decim_q, decim_d, decim_eff;
   logic              ovf_q, ovf_d;
   logic              awready_q, awready_d, bvalid_q, bvalid_d;
   logic              arready_q, arready_d, rd_s1_q, rd_s1_d, rvalid_q, rvalid_d;
   logic [AW-1:0]     ar_addr_q, ar_addr_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              wr_hs, ar_hs, ctrl_wr, decim_wr, start, clr_ovf, accept, last;
   logic              busy, done;
   logic [NB_CHAN*SW-1:0] ram_wdata;
   logic [SW-1:0]     ram_rdata;
   logic [DW-1:0]     ram_word, status_w, reg_rd;
   logic [AW-2:0]     ram_off;
   logic              ram_hit;
   logic              unused_bits;
   assign unused_bits = ^{s00_axi_wdata[DW-1:16], s00_axi_wstrb[DW/8-1:2]};
   for (genvar k = 0; k < NB_CHAN; k++) begin : g_pack
      assign ram_wdata[k*SW +: SW] = {data_q_i[k*DATA_SIZE +: DATA_SIZE], data_i_i[k*DATA_SIZE +: DATA_SIZE]};
   end
   // Read address goes straight to the RAM so its registered output lines up with rd_s1_q
   iq_ram_polling_mc_ram #(
      .DATA_W(SW), .NB_CHAN(NB_CHAN), .CHAN_LOG2(CHAN_LOG2), .DEPTH_LOG2(RAM_DEPTH_LOG2)
   ) u_ram (
      .clk(s00_axi_aclk),
      .we(accept),
      .waddr(wr_ptr_q[RAM_DEPTH_LOG2-1:0]),
      .wdata(ram_wdata),
      .raddr(s00_axi_araddr[2 +: RW]),
      .rdata(ram_rdata)
   );
   always_comb begin
      wr_hs     = awready_q && s00_axi_awvalid && s00_axi_wvalid;
      ar_hs     = arready_q && s00_axi_arvalid;
      ctrl_wr   = wr_hs && s00_axi_awaddr == AW'(REG_CTRL);
      decim_wr  = wr_hs && s00_axi_awaddr == AW'(REG_DECIM);
      start     = ctrl_wr && s00_axi_wdata[CTRL_START];
      clr_ovf   = ctrl_wr && s00_axi_wdata[CTRL_CLR_OVF];
      decim_eff = decim_q == '0 ? 16'd1 : decim_q;
      accept    = state_q == CAPTURE && data_en_i && dcnt_q >= decim_eff - 16'd1 && !start;
      last      = wr_ptr_q == PW'(2**RAM_DEPTH_LOG2 - 1);
   end
   always_comb state_d = start ? CAPTURE : (accept && last) ? DONE : state_q;
   always_comb begin
      irq_o = state_q == DONE;
      busy  = state_q == CAPTURE;
      done  = state_q == DONE;
   end
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) state_q <= IDLE;
      else               state_q <= state_d;
   end
   always_comb begin
      wr_ptr_d  = start ? '0 : accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      dcnt_d    = start ? '0 : accept ? '0 : (busy && data_en_i) ? dcnt_q + 16'd1 : dcnt_q;
      ovf_d     = (done && data_en_i) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
      decim_d   = decim_wr ? {s00_axi_wstrb[1] ? s00_axi_wdata[15:8] : decim_q[15:8],
                              s00_axi_wstrb[0] ? s00_axi_wdata[7:0]  : decim_q[7:0]} : decim_q;
      awready_d = s00_axi_awvalid && s00_axi_wvalid && !awready_q && !bvalid_q;
      bvalid_d  = wr_hs || (bvalid_q && !s00_axi_bready);
      arready_d = s00_axi_arvalid && !arready_q && !rd_s1_q && !rvalid_q;
      rd_s1_d   = ar_hs;
      ar_addr_d = ar_hs ? s00_axi_araddr : ar_addr_q;
      rvalid_d  = rd_s1_q || (rvalid_q && !s00_axi_rready);
      rdata_d   = rd_s1_q ? reg_rd : rdata_q;
   end
   // RAM window decodes only aligned in-range {chan, index} words; anything else reads 0
   always_comb begin
      ram_off  = ar_addr_q[AW-2:0];
      ram_hit  = ar_addr_q[AW-1] && (ram_off >> (RW + 2)) == '0 && ram_off[1:0] == 2'b00 &&
                 int'(ram_off[2+RAM_DEPTH_LOG2 +: CHAN_LOG2]) < NB_CHAN;
      ram_word = {16'($signed(ram_rdata[SW-1:DATA_SIZE])), 16'($signed(ram_rdata[DATA_SIZE-1:0]))};
      status_w = '0;
      status_w[STAT_BUSY] = busy;
      status_w[STAT_DONE] = done;
      status_w[STAT_OVF]  = ovf_q;
      reg_rd   = ram_hit                          ? ram_word :
                 ar_addr_q == AW'(REG_STATUS)     ? status_w :
                 ar_addr_q == AW'(REG_DECIM)      ? DW'(decim_q) :
                 ar_addr_q == AW'(REG_FILL)       ? DW'(wr_ptr_q) : '0;
   end
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         wr_ptr_q  <= '0;
         dcnt_q    <= '0;
         ovf_q     <= 1'b0;
         decim_q   <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rd_s1_q   <= 1'b0;
         ar_addr_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         dcnt_q    <= dcnt_d;
         ovf_q     <= ovf_d;
         decim_q   <= decim_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rd_s1_q   <= rd_s1_d;
         ar_addr_q <= ar_addr_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end
   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = 2'b00;
   assign s00_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_iq_ram_polling_mc.sv
// tb_iq_ram_polling_mc: scenario tasks driving capture and AXI traffic; expected read data
// is queued when a read is planned and compared when the read completes
module tb_iq_ram_polling_mc;
   localparam int AW = 12, DS = 16, NC = 2;
   localparam logic [AW-1:0] A_CTRL = 12'h000, A_STATUS = 12'h004, A_DECIM = 12'h008, A_FILL = 12'h00C;
   logic clk = 1'b0, rst = 1'b1;
   logic data_en = 1'b0;
   logic [NC*DS-1:0] data_i = '0, data_q = '0;
   logic irq;
   logic [AW-1:0] awaddr = '0, araddr = '0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0] wstrb = '0;
   logic awready, wready, bvalid, arready, rvalid;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;
   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [AW-1:0] adr_q[$];
   string nm_q[$];

   always #5 clk = ~clk;

   iq_ram_polling_mc dut (
      .s00_axi_aclk(clk), .s00_axi_reset(rst),
      .data_en_i(data_en), .data_i_i(data_i), .data_q_i(data_q), .irq_o(irq),
      .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
   );

   function automatic logic [31:0] samp(int ch, int n);
      logic [15:0] i, q;
      i = ch == 0 ? 16'(n) : 16'(n + 1000);
      q = ch == 0 ? 16'(-n) : 16'(n * 3);
      return {q, i};
   endfunction

   function automatic logic [AW-1:0] ram_a(int ch, int idx);
      return AW'(32'h800 + ch * 1024 + idx * 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
      adr_q.push_back(a);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input logic en_at_hs);
      int n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      while (!awready && n < 20) begin tick(); n++; end
      data_en = en_at_hs;
      tick();
      data_en = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++;
         $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b, required 1/00", a, bvalid, bresp);
      end
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      while (!arready && n < 20) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (rvalid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL read_timeout addr=%h: rvalid=%b, required 1", a, rvalid);
      end
      d = rdata;
      tick();
      rready = 1'b0;
   endtask

   task automatic strobe(input int cnt, input int base);
      for (int k = 0; k < cnt; k++) begin
         for (int c = 0; c < NC; c++) begin
            logic [31:0] w;
            w = samp(c, base + k);
            data_i[c*DS +: DS] = w[15:0];
            data_q[c*DS +: DS] = w[31:16];
         end
         data_en = 1'b1;
         tick();
      end
      data_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] got, e;
      string nm;
      repeat (3) tick();
      checks++;
      if ({irq, awready, wready, bvalid, arready, rvalid} !== 6'b0 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: irq/aw/w/b/ar/r=%b rdata=%h, required all 0", {irq, awready, wready, bvalid, arready, rvalid}, rdata);
      end
      rst = 1'b0;
      push(A_STATUS, 32'h0, "reset_status");
      push(A_FILL, 32'h0, "reset_fill");
      push(A_DECIM, 32'h0, "reset_decim");
      push(A_CTRL, 32'h0, "ctrl_reads_zero");
      push(12'h010, 32'h0, "undecoded_zero");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   task automatic test_capture();
      logic [31:0] got, e;
      string nm;
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0);
      strobe(255, 0);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL cap_irq_early: irq=%b, required 0", irq); end
      push(A_STATUS, 32'h1, "cap_status_busy");
      push(A_FILL, 32'd255, "cap_fill_255");
      push(ram_a(0, 7), samp(0, 7), "cap_read_during_capture");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      strobe(1, 255);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL cap_irq_done: irq=%b, required 1", irq); end
      push(A_STATUS, 32'h2, "cap_status_done");
      push(ram_a(0, 5), 32'hFFFB0005, "cap_ch0_idx5");
      push(ram_a(1, 5), 32'h000F03ED, "cap_ch1_idx5");
      push(ram_a(0, 0), samp(0, 0), "cap_ch0_idx0");
      push(ram_a(0, 255), samp(0, 255), "cap_ch0_idx255");
      push(ram_a(1, 255), samp(1, 255), "cap_ch1_idx255");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   task automatic test_decim();
      logic [31:0] got, e;
      string nm;
      axi_write(A_DECIM, 32'h4, 4'hF, 1'b0);
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0);
      strobe(1023, 0);
      push(A_STATUS, 32'h1, "dec_status_busy");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      strobe(1, 1023);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL dec_irq_done: irq=%b, required 1", irq); end
      push(A_STATUS, 32'h2, "dec_status_done");
      push(A_DECIM, 32'h4, "dec_readback");
      push(ram_a(0, 0), samp(0, 3), "dec_ch0_idx0");
      push(ram_a(0, 5), samp(0, 23), "dec_ch0_idx5");
      push(ram_a(1, 100), samp(1, 403), "dec_ch1_idx100");
      push(ram_a(0, 255), samp(0, 1023), "dec_ch0_idx255");
      push(ram_a(1, 255), samp(1, 1023), "dec_ch1_idx255");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] got, e;
      string nm;
      strobe(3, 2000);
      push(A_STATUS, 32'h6, "ovf_set");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      axi_write(A_CTRL, 32'h2, 4'hF, 1'b1);
      push(A_STATUS, 32'h6, "ovf_set_beats_clear");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      axi_write(A_CTRL, 32'h2, 4'hF, 1'b0);
      push(A_STATUS, 32'h2, "ovf_cleared");
      push(ram_a(0, 255), samp(0, 1023), "ovf_ram_untouched");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   task automatic test_restart_reset();
      logic [31:0] got, e;
      string nm;
      axi_write(A_DECIM, 32'h1, 4'hF, 1'b0);
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0);
      strobe(10, 3000);
      axi_write(A_CTRL, 32'h1, 4'hF, 1'b0);
      push(A_FILL, 32'h0, "restart_fill_cleared");
      push(A_STATUS, 32'h1, "restart_status_busy");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      strobe(100, 5000);
      push(A_FILL, 32'd100, "mid_fill_100");
      push(ram_a(0, 50), samp(0, 5050), "mid_ch0_idx50_new");
      push(ram_a(1, 99), samp(1, 5099), "mid_ch1_idx99_new");
      push(ram_a(0, 150), samp(0, 603), "mid_ch0_idx150_old");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: irq=%b, required 0", irq); end
      push(A_STATUS, 32'h0, "rst_status_idle");
      push(A_FILL, 32'h0, "rst_fill");
      push(A_DECIM, 32'h0, "rst_decim");
      push(ram_a(0, 50), samp(0, 5050), "rst_ram_kept");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got, e, held;
      string nm;
      logic aw_done, ar_done, aw_nx, ar_nx;
      int n;
      aw_done = 1'b0; ar_done = 1'b0; n = 0;
      held = samp(0, 5050);
      awaddr = A_DECIM; wdata = 32'h0000ABCD; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
      araddr = ram_a(0, 50); arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
      while (!(aw_done && ar_done) && n < 30) begin
         aw_nx = awready; ar_nx = arready;
         tick(); n++;
         aw_done |= aw_nx; ar_done |= ar_nx;
      end
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      checks++;
      if (!aw_done || !ar_done) begin
         errors++;
         $display("FAIL bp_handshake: aw_done=%b ar_done=%b, required 1/1", aw_done, ar_done);
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== held || awready !== 1'b0 || arready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: bvalid=%b rvalid=%b rdata=%h awready=%b arready=%b, required 1 1 %h 0 0",
                     c, bvalid, rvalid, rdata, awready, arready, held);
         end
         tick();
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: bvalid=%b rvalid=%b, required 0 0", bvalid, rvalid);
      end
      push(A_DECIM, 32'h000000CD, "wstrb_decim_low_byte");
      while (adr_q.size() > 0) begin
         axi_read(adr_q.pop_front(), got);
         e = exp_q.pop_front(); nm = nm_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL %s: got %h, required %h", nm, got, e); end
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_decim();
      test_overflow();
      test_restart_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end
endmodule
